// File: rtl/mopshub_elink_pkg.sv
// Shared definitions for the E-link deserializer sequencer and comma detector.
// Holds the demux slot count, the K28.5 comma codes in both running disparities,
// the sequencer state encoding and a bit-reversal helper for the comma compare.
package mopshub_elink_pkg;

    // A 10-bit word arrives as five 2-bit slices
    localparam int unsigned SLOT_NUM = 5;

    // K28.5 comma, negative and positive running disparity
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // ST_RUN is used by the plain build; ST_HUNT/ST_LOCKED replace it
    // when automatic comma alignment is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    function automatic logic [9:0] bitrev10(input logic [9:0] w);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = w[9-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/elink_comma_det.sv
// Combinational K28.5 comma detector for a demux-assembled 10-bit word.
// Ports: word_i (assembled word, slot0 = bits[1:0]), match_o (comma seen).
// The line may transmit MSB- or LSB-first, so both bit orders of both
// disparities are accepted.
module elink_comma_det
    import mopshub_elink_pkg::*;
(
    input  logic [9:0] word_i,
    output logic       match_o
);

    assign match_o = (word_i == K28_5_RDN) ||
                     (word_i == K28_5_RDP) ||
                     (word_i == bitrev10(K28_5_RDN)) ||
                     (word_i == bitrev10(K28_5_RDP));

endmodule

// File: rtl/elink_deser_ctrl.sv
// Sequencer for the 2-bit-to-10-bit E-link demux: drives the slot select,
// registers each assembled word with a one-cycle word_valid (1 clk after the
// slot-4 beat), counts words and supports bit-pair slip.
// Ports: clk/rst (sync, active high), enable, edata_valid, slip_req,
// enc10bit_in -> sel, word_out, word_valid, word_cnt, locked.
// Optional macro COMMA_ALIGN_EN adds K28.5 hunting (HUNT/LOCKED sub-states).
module elink_deser_ctrl
    import mopshub_elink_pkg::*;
#(
    parameter int N         = 10,
    parameter int CNT_W     = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             edata_valid,
    input  logic             slip_req,
    input  logic [N-1:0]     enc10bit_in,
    output logic [2:0]       sel,
    output logic [N-1:0]     word_out,
    output logic             word_valid,
    output logic [CNT_W-1:0] word_cnt,
    output logic             locked
);

    if (N != 10 || SLIP_WAIT < 0) begin : g_bad_param
        $error("elink_deser_ctrl: only N=10 and SLIP_WAIT>=0 are supported");
    end

    localparam logic [2:0] SLOT_LAST = 3'(SLOT_NUM - 1);

`ifdef COMMA_ALIGN_EN
    localparam state_e     RUN_ENTRY = ST_HUNT;
    localparam int         WAIT_W    = $clog2(SLIP_WAIT + 1) > 0 ? $clog2(SLIP_WAIT + 1) : 1;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  comma_match;

    elink_comma_det u_comma_det (
        .word_i  (enc10bit_in),
        .match_o (comma_match)
    );
`else
    localparam state_e     RUN_ENTRY = ST_RUN;
`endif

    state_e            state_q, state_d;
    logic [2:0]        slot_q, slot_d;
    logic              slip_pending_q, slip_pending_d;
    logic [N-1:0]      word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            slot_q         <= '0;
            slip_pending_q <= 1'b0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            cnt_q          <= '0;
`ifdef COMMA_ALIGN_EN
            wait_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            slip_pending_q <= slip_pending_d;
            word_q         <= word_d;
            word_valid_q   <= word_valid_d;
            cnt_q          <= cnt_d;
`ifdef COMMA_ALIGN_EN
            wait_q         <= wait_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        slip_pending_d = slip_pending_q;
        word_d         = word_q;
        word_valid_d   = 1'b0;
        cnt_d          = cnt_q;
        capture        = 1'b0;
`ifdef COMMA_ALIGN_EN
        wait_d         = wait_q;
`endif
        if (state_q == ST_IDLE) begin
            slot_d         = '0;
            slip_pending_d = 1'b0;
            if (enable) begin
                state_d = RUN_ENTRY;
            end
        end else if (!enable) begin
            // Partial word is dropped; counting restarts at slot 0.
            state_d        = ST_IDLE;
            slot_d         = '0;
            slip_pending_d = 1'b0;
`ifdef COMMA_ALIGN_EN
            wait_d         = '0;
`endif
        end else begin
            if (edata_valid) begin
                if (slip_pending_q) begin
                    // Slot holds: this beat overwrites the same demux slot.
                    slip_pending_d = 1'b0;
                end else if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    capture = 1'b1;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            // A request on the consuming beat (or while pending) is dropped.
            if (slip_req && !(edata_valid && slip_pending_q)) begin
                slip_pending_d = 1'b1;
            end
`ifdef COMMA_ALIGN_EN
            if (state_q == ST_LOCKED) begin
                if (capture) begin
                    word_d       = enc10bit_in;
                    word_valid_d = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                end
                if (slip_req) begin
                    state_d = ST_HUNT;
                end
            end else if (capture) begin
                // Hunting: after an internal slip, let the pipeline settle
                // for SLIP_WAIT words before trusting a compare again.
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (comma_match) begin
                    state_d = ST_LOCKED;
                end else begin
                    slip_pending_d = 1'b1;
                    wait_d         = WAIT_W'(SLIP_WAIT);
                end
            end
`else
            if (capture) begin
                word_d       = enc10bit_in;
                word_valid_d = 1'b1;
                cnt_d        = cnt_q + 1'b1;
            end
`endif
        end
    end

    assign sel        = slot_q;
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign word_cnt   = cnt_q;
`ifdef COMMA_ALIGN_EN
    assign locked     = (state_q == ST_LOCKED);
`else
    assign locked     = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_elink_deser_ctrl.sv
// Self-checking bench for elink_deser_ctrl (default build, no comma hunting).
// Directed opening sequence, then randomized enable/valid/slip/reset traffic
// compared every cycle against a behavioural word-assembly model.
module tb_elink_deser_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, edata_valid, slip_req;
    logic [9:0]  enc10bit_in;
    logic [2:0]  sel;
    logic [9:0]  word_out;
    logic        word_valid;
    logic [15:0] word_cnt;
    logic        locked;

    int checks = 0;
    int errors = 0;

    // Reference model: a word is five accepted slices; a pending slip makes
    // the next slice land on the same slot instead of advancing.
    bit          m_run;
    int          m_pos;      // slices accepted toward current word, 0..4
    bit          m_slip;
    bit          m_wv;
    logic [9:0]  m_word;
    int unsigned m_words;

    always #5 clk = ~clk;

    elink_deser_ctrl #(.N(10), .CNT_W(16), .SLIP_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .edata_valid (edata_valid),
        .slip_req    (slip_req),
        .enc10bit_in (enc10bit_in),
        .sel         (sel),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_cnt    (word_cnt),
        .locked      (locked)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v, input bit s,
                              input logic [9:0] d);
        bit was_pending;
        m_wv = 1'b0;
        if (r) begin
            m_run = 0; m_pos = 0; m_slip = 0; m_word = '0; m_words = 0;
        end else if (!m_run || !e) begin
            m_run  = e && !m_run;
            m_pos  = 0;
            m_slip = 0;
        end else begin
            was_pending = m_slip;
            if (v) begin
                if (was_pending) begin
                    m_slip = 0;
                end else if (m_pos == 4) begin
                    m_pos   = 0;
                    m_word  = d;
                    m_wv    = 1'b1;
                    m_words = (m_words + 1) % 65536;
                end else begin
                    m_pos++;
                end
            end
            if (s && !(v && was_pending)) m_slip = 1;
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge), update the
    // model at the edge and compare outputs 1 time unit later.
    task automatic cycle(input bit r, input bit e, input bit v, input bit s,
                         input logic [9:0] d);
        rst = r; enable = e; edata_valid = v; slip_req = s; enc10bit_in = d;
        @(posedge clk);
        model_step(r, e, v, s, d);
        #1;
        chk("sel", 32'(sel), 32'(m_pos));
        chk("word_valid", 32'(word_valid), 32'(m_wv));
        chk("word_cnt", 32'(word_cnt), m_words);
        chk("locked", 32'(locked), 32'(m_run));
        if (m_wv) chk("word_out", 32'(word_out), 32'(m_word));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; edata_valid = 1'b0; slip_req = 1'b0; enc10bit_in = '0;
        m_run = 0; m_pos = 0; m_slip = 0; m_wv = 0; m_word = '0; m_words = 0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0, 10'h3FF);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_word_out", 32'(word_out), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);

        // Enable, then ten back-to-back beats: words 2AA and 155
        cycle(0, 1, 0, 0, 10'h000);
        chk("run_locked", 32'(locked), 32'd1);
        for (int b = 1; b <= 10; b++) begin
            cycle(0, 1, 1, 0, (b == 5) ? 10'h2AA : (b == 10) ? 10'h155 : 10'h0F0);
            chk("seq_sel", 32'(sel), 32'(b % 5));
            if (b == 5) chk("word1", 32'(word_out), 32'h2AA);
        end
        chk("word2", 32'(word_out), 32'h155);
        chk("two_words", 32'(word_cnt), 32'd2);

        // Slip at slot 2: next beat holds sel=2, word needs six beats
        cycle(0, 1, 1, 0, 10'h001);
        cycle(0, 1, 1, 0, 10'h002);
        cycle(0, 1, 0, 1, 10'h003);
        cycle(0, 1, 1, 0, 10'h004);
        chk("slip_hold", 32'(sel), 32'd2);
        cycle(0, 1, 1, 0, 10'h005);
        cycle(0, 1, 1, 0, 10'h006);
        chk("slip_no_early", 32'(word_valid), 32'd0);
        cycle(0, 1, 1, 0, 10'h1C7);
        chk("slip_word", 32'(word_out), 32'h1C7);

        // Enable dropped mid-word: no word, sel back to 0
        cycle(0, 1, 1, 0, 10'h000);
        cycle(0, 1, 1, 0, 10'h000);
        cycle(0, 1, 1, 0, 10'h000);
        cycle(0, 0, 1, 0, 10'h000);
        chk("drop_sel", 32'(sel), 32'd0);
        chk("drop_nowv", 32'(word_valid), 32'd0);

        // Randomized traffic including gapped valids, slips and resets
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 29) != 0),
                  ($urandom_range(0, 2) == 0) || (i % 1000 < 300),
                  ($urandom_range(0, 11) == 0),
                  10'($urandom_range(0, 1023)));
        end

        // Reset mid-word after some words
        cycle(0, 1, 1, 0, 10'h000);
        cycle(1, 1, 1, 0, 10'h000);
        chk("rst2_cnt", 32'(word_cnt), 32'd0);
        chk("rst2_sel", 32'(sel), 32'd0);
        chk("rst2_out", 32'(word_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
